// File: rtl/thor2024_alu_seq_if.sv
// Instruction format shared by the issue side and the ALU, plus the sequencer bus.
// The slave modport faces the sequencer; the master modport faces issue logic, consumer and ALU.
`timescale 1ns/1ps
package thor2024_alu_seq_pkg;
  localparam logic [6:0] OP_R2    = 7'h02;
  localparam logic [6:0] OP_ADDI  = 7'h04;
  localparam logic [6:0] OP_MULI  = 7'h06;
  localparam logic [6:0] OP_ANDI  = 7'h08;
  localparam logic [6:0] OP_MULUI = 7'h0E;
  localparam logic [6:0] OP_DIVI  = 7'h10;
  localparam logic [6:0] OP_DIVUI = 7'h11;

  localparam logic [6:0] FN_ADD   = 7'h04;
  localparam logic [6:0] FN_SUB   = 7'h05;
  localparam logic [6:0] FN_AND   = 7'h08;
  localparam logic [6:0] FN_MUL   = 7'h10;
  localparam logic [6:0] FN_MULU  = 7'h11;
  localparam logic [6:0] FN_MULH  = 7'h12;
  localparam logic [6:0] FN_MULUH = 7'h13;
  localparam logic [6:0] FN_DIV   = 7'h18;
  localparam logic [6:0] FN_DIVU  = 7'h19;
  localparam logic [6:0] FN_MOD   = 7'h1A;
  localparam logic [6:0] FN_MODU  = 7'h1B;

  typedef struct packed {
    logic [6:0] fn;
    logic [5:0] rc;
    logic [5:0] rb;
    logic [5:0] ra;
    logic [6:0] opcode;
  } instruction_t;
endpackage

interface thor2024_alu_seq_if;
  import thor2024_alu_seq_pkg::*;

  logic         issue_v;
  logic         issue_rdy;
  instruction_t issue_ir;
  logic [4:0]   issue_tag;
  logic [63:0]  issue_a, issue_b, issue_c, issue_t, issue_p;

  instruction_t alu_ir;
  logic [63:0]  alu_a, alu_b, alu_c, alu_t, alu_p;
  logic         alu_div;
  logic [63:0]  alu_o;
  logic         alu_mul_done, alu_div_done, alu_div_dbz;

  logic         res_v;
  logic         res_rdy;
  logic [4:0]   res_tag;
  logic [63:0]  res_val;
  logic         res_exc;

  modport slave (
    input  issue_v, issue_ir, issue_tag, issue_a, issue_b, issue_c, issue_t, issue_p,
    input  alu_o, alu_mul_done, alu_div_done, alu_div_dbz, res_rdy,
    output issue_rdy, alu_ir, alu_a, alu_b, alu_c, alu_t, alu_p, alu_div,
    output res_v, res_tag, res_val, res_exc
  );

  modport master (
    output issue_v, issue_ir, issue_tag, issue_a, issue_b, issue_c, issue_t, issue_p,
    output alu_o, alu_mul_done, alu_div_done, alu_div_dbz, res_rdy,
    input  issue_rdy, alu_ir, alu_a, alu_b, alu_c, alu_t, alu_p, alu_div,
    input  res_v, res_tag, res_val, res_exc
  );
endinterface

// File: rtl/thor2024_alu_seq.sv
// Single-op ALU sequencer: registers operands, waits out multi-cycle MUL/DIV, holds the result.
// Macro THOR2024_ALU_SEQ_DBZ_EXC_EN enables divide-by-zero reporting on res_exc.
`timescale 1ns/1ps
module thor2024_alu_seq
  import thor2024_alu_seq_pkg::*;
(
  input logic             clk,
  input logic             rst,
  thor2024_alu_seq_if.slave io_bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_EXEC, S_WAIT, S_DONE} state_t;

  state_t       r_state;
  instruction_t r_alu_ir;
  logic [63:0]  r_alu_a, r_alu_b, r_alu_c, r_alu_t, r_alu_p;
  logic         r_alu_div;
  logic         r_is_div;
  logic         r_pfalse;
  logic [1:0]   r_guard;
  logic [4:0]   r_res_tag;
  logic [63:0]  r_res_val;

  logic w_r2, w_mul, w_div, w_sdiv, w_long, w_wait_done;

  always_comb begin
    w_r2   = (io_bus.issue_ir.opcode == OP_R2);
    w_mul  = (w_r2 && (io_bus.issue_ir.fn inside {FN_MUL, FN_MULU, FN_MULH, FN_MULUH}))
           || (io_bus.issue_ir.opcode inside {OP_MULI, OP_MULUI});
    w_div  = (w_r2 && (io_bus.issue_ir.fn inside {FN_DIV, FN_MOD, FN_DIVU, FN_MODU}))
           || (io_bus.issue_ir.opcode inside {OP_DIVI, OP_DIVUI});
    w_sdiv = (w_r2 && (io_bus.issue_ir.fn inside {FN_DIV, FN_MOD}))
           || (io_bus.issue_ir.opcode == OP_DIVI);
    // A predicated-off op never waits on the ALU; it just returns the old target.
    w_long = io_bus.issue_p[0] && (w_mul || w_div);
  end

  // The done lines may still be high from a previous op with equal operands, hence the guard.
  assign w_wait_done = (r_state == S_WAIT) && (r_guard == 2'd0)
                     && (r_is_div ? io_bus.alu_div_done : io_bus.alu_mul_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_alu_ir  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_c   <= '0;
      r_alu_t   <= '0;
      r_alu_p   <= '0;
      r_alu_div <= 1'b0;
      r_is_div  <= 1'b0;
      r_pfalse  <= 1'b0;
      r_guard   <= '0;
      r_res_tag <= '0;
      r_res_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.issue_v) begin
          r_alu_ir  <= io_bus.issue_ir;
          r_alu_c   <= io_bus.issue_c;
          r_alu_t   <= io_bus.issue_t;
          r_alu_p   <= io_bus.issue_p;
          r_alu_div <= w_sdiv;
          r_is_div  <= w_div;
          r_pfalse  <= ~io_bus.issue_p[0];
          r_res_tag <= io_bus.issue_tag;
          if (w_long) begin
            // Inverted operands guarantee the ALU sees an argument change next cycle.
            r_alu_a <= ~io_bus.issue_a;
            r_alu_b <= ~io_bus.issue_b;
            r_state <= S_PRIME;
          end else begin
            r_alu_a <= io_bus.issue_a;
            r_alu_b <= io_bus.issue_b;
            r_state <= S_EXEC;
          end
        end
        S_PRIME: begin
          r_alu_a <= ~r_alu_a;
          r_alu_b <= ~r_alu_b;
          r_guard <= 2'd2;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_guard != 2'd0)
            r_guard <= r_guard - 2'd1;
          if (w_wait_done) begin
            r_res_val <= io_bus.alu_o;
            r_state   <= S_DONE;
          end
        end
        S_EXEC: begin
          r_res_val <= r_pfalse ? r_alu_t : io_bus.alu_o;
          r_state   <= S_DONE;
        end
        S_DONE: if (io_bus.res_rdy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef THOR2024_ALU_SEQ_DBZ_EXC_EN
  logic r_res_exc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_res_exc <= 1'b0;
    else if (w_wait_done)
      r_res_exc <= r_is_div & io_bus.alu_div_dbz;
    else if (r_state == S_EXEC)
      r_res_exc <= 1'b0;
  end
  assign io_bus.res_exc = r_res_exc;
`else
  assign io_bus.res_exc = 1'b0;
`endif

  assign io_bus.issue_rdy = rst && (r_state == S_IDLE);
  assign io_bus.res_v     = (r_state == S_DONE);
  assign io_bus.res_tag   = r_res_tag;
  assign io_bus.res_val   = r_res_val;
  assign io_bus.alu_ir    = r_alu_ir;
  assign io_bus.alu_a     = r_alu_a;
  assign io_bus.alu_b     = r_alu_b;
  assign io_bus.alu_c     = r_alu_c;
  assign io_bus.alu_t     = r_alu_t;
  assign io_bus.alu_p     = r_alu_p;
  assign io_bus.alu_div   = r_alu_div;

endmodule
